// File: rtl/viterbi_decoder.sv
// Hard-decision K=3 rate-1/2 (7,5) Viterbi decoder, register-exchange survivors.
// Define VITERBI_PM_NORM_EN for min-subtract path-metric normalisation.
module viterbi_decoder #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] d_in,
  output logic       d_out
);

  localparam int SW = PM_W + 1;
  localparam int FW = $clog2(TB_DEPTH + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(TB_DEPTH);
  localparam logic [PM_W-1:0] PM_MAX = '1;
  localparam logic [PM_W-1:0] PM_BIAS = PM_W'(1) << (PM_W - 2);

  logic [PM_W-1:0]     pm      [4];
  logic [PM_W-1:0]     pm_nx   [4];
  logic [TB_DEPTH-1:0] surv    [4];
  logic [TB_DEPTH-1:0] surv_nx [4];
  logic [SW-1:0]       acs     [4];
  logic [3:0]          win;
  logic [SW-1:0]       mn;
  logic [1:0]          best;
  logic [PM_W-1:0]     best_pm;
  logic [FW-1:0]       fill;

  function automatic logic [1:0] bm(
    input logic [1:0] p,
    input logic       u,
    input logic [1:0] sym
  );
    logic [1:0] x;
    x = {u ^ p[1] ^ p[0], u ^ p[0]} ^ sym;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat(
    input logic [SW-1:0] v
  );
    return (v > SW'(PM_MAX)) ? PM_MAX : v[PM_W-1:0];
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_acs
    localparam logic [1:0] NS = 2'(g);
    localparam logic [1:0] P0 = {NS[0], 1'b0};
    localparam logic [1:0] P1 = {NS[0], 1'b1};
    logic [SW-1:0] c0;
    logic [SW-1:0] c1;
    assign c0 = SW'(pm[P0]) + SW'(bm(P0, NS[1], d_in));
    assign c1 = SW'(pm[P1]) + SW'(bm(P1, NS[1], d_in));
    // strict compare: ties go to the lower-index predecessor
    assign win[g] = c1 < c0;
    assign acs[g] = win[g] ? c1 : c0;
    assign surv_nx[g] = {win[g] ? surv[P1][TB_DEPTH-2:0]
                                : surv[P0][TB_DEPTH-2:0], NS[1]};
  end

  always_comb begin
    mn = acs[0];
    for (int i = 1; i < 4; i++)
      if (acs[i] < mn) mn = acs[i];
    for (int i = 0; i < 4; i++) begin
`ifdef VITERBI_PM_NORM_EN
      pm_nx[i] = sat(acs[i] - mn);
`else
      pm_nx[i] = sat(acs[i]);
`endif
    end
  end

  always_comb begin
    best    = 2'd0;
    best_pm = pm[0];
    for (int i = 1; i < 4; i++)
      if (pm[i] < best_pm) begin
        best    = 2'(i);
        best_pm = pm[i];
      end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm[0] <= '0;
      for (int i = 1; i < 4; i++) pm[i] <= PM_BIAS;
      for (int i = 0; i < 4; i++) surv[i] <= '0;
      fill  <= '0;
      d_out <= 1'b0;
    end else if (enable) begin
      for (int i = 0; i < 4; i++) begin
        pm[i]   <= pm_nx[i];
        surv[i] <= surv_nx[i];
      end
      if (fill != FILL_MAX) fill <= fill + FW'(1);
      d_out <= (fill == FILL_MAX) ? surv[best][TB_DEPTH-1] : 1'b0;
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench for viterbi_decoder: directed streams, errors,
// enable gaps, mid-stream reset and narrow-metric saturation.
module tb_viterbi_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] d_in = 2'b00;
  logic       d_out;
  logic       en4 = 1'b0;
  logic [1:0] d4 = 2'b00;
  logic       d_out4;

  always #5 clk = ~clk;

  viterbi_decoder #(.TB_DEPTH(16), .PM_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .d_in(d_in), .d_out(d_out)
  );

  viterbi_decoder #(.TB_DEPTH(16), .PM_W(4)) dut4 (
    .clk(clk), .rst(rst), .enable(en4),
    .d_in(d4), .d_out(d_out4)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic       exp_q[$];
  logic       hist[$];
  logic       last_exp = 1'b0;
  int         n_sym = 0;
  logic [1:0] enc = 2'b00;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // monitor: every enabled edge yields one scoreboard entry
  initial begin : monitor
    logic e;
    forever begin
      @(posedge clk);
      if (rst) begin
        if (enable) begin
          #1;
          if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            last_exp = e;
            check("d_out", {31'd0, d_out}, {31'd0, e});
          end
        end else begin
          #1;
          check("d_out_hold", {31'd0, d_out}, {31'd0, last_exp});
        end
      end
    end
  end

  task automatic send(input logic u, input logic flip);
    logic [1:0] c;
    c = {u ^ enc[1] ^ enc[0], u ^ enc[0]};
    enc = {u, enc[1]};
    d_in = c ^ {1'b0, flip};
    enable = 1'b1;
    hist.push_back(u);
    n_sym++;
    exp_q.push_back(n_sym > 16 ? hist[n_sym-17] : 1'b0);
    @(negedge clk);
  endtask

  task automatic idle();
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_d_out", {31'd0, d_out}, 32'd0);
    check("rst_q_empty", exp_q.size(), 32'd0);
    check("rst_pm0", {24'd0, dut.pm[0]}, 32'd0);
    check("rst_pm1", {24'd0, dut.pm[1]}, 32'd64);
    exp_q.delete();
    hist.delete();
    n_sym = 0;
    enc = 2'b00;
    last_exp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [3:0] pat;
    logic       b;
    logic [3:0] m;
    pat = 4'b1101;
    @(negedge clk);
    do_reset();

    // 1,0,1,1 -> symbols 11,10,00,01 then zero padding
    for (int i = 0; i < 4; i++) send(pat[i], 1'b0);
    for (int i = 0; i < 20; i++) send(1'b0, 1'b0);
    idle();

    do_reset();
    for (int i = 0; i < 300; i++) send(1'b0, 1'b0);
    idle();
    check("zero_pm0", {24'd0, dut.pm[0]}, 32'd0);

    // random data, d_in[0] flipped every 8th symbol, 3-cycle gap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i == 100) begin
        idle();
        idle();
        idle();
      end
      b = 1'($urandom_range(0, 1));
      send(b, (i % 8) == 7);
    end
    for (int i = 0; i < 20; i++) send(1'b0, 1'b0);
    idle();

    // mid-stream reset while d_out is 1
    do_reset();
    for (int i = 0; i < 40; i++) send(1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 60; i++) begin
      b = 1'($urandom_range(0, 1));
      send(b, 1'b0);
    end
    for (int i = 0; i < 20; i++) send(1'b0, 1'b0);
    idle();

    // PM_W=4: symbols 11 against an all-zero code stream
    for (int i = 0; i < 100; i++) begin
      en4 = 1'b1;
      d4 = 2'b11;
      @(negedge clk);
    end
    en4 = 1'b0;
    @(negedge clk);
`ifdef VITERBI_PM_NORM_EN
    m = dut4.pm[0];
    for (int i = 1; i < 4; i++)
      if (dut4.pm[i] < m) m = dut4.pm[i];
    check("norm4_min", {28'd0, m}, 32'd0);
`else
    for (int i = 0; i < 4; i++)
      check($sformatf("sat4_pm%0d", i), {28'd0, dut4.pm[i]}, 32'd15);
`endif

    check("sb_drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
